// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory bus bundle for load_store_unit.
// The LSU uses the slave modport; the core/memory environment uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: lane steering, byte enables, load extension.
// Optional WAIT-state abort after TIMEOUT cycles when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      lsu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_rep;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic        timeout_hit;

    // Elaboration-only reference; TIMEOUT has no effect without the timeout feature.
    if (TIMEOUT < 1) begin : g_timeout_below_one
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CW-1:0] wait_cnt;
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign lsu.req_ready = (state == IDLE);
    assign lsu.stall     = rst_n && (((state == IDLE) && lsu.req_valid) || (state == WAIT));

    always_comb begin
        legal     = 1'b0;
        be_next   = 4'b0000;
        wdata_rep = lsu.req_wdata;
        case (lsu.req_size)
            2'b00: begin
                legal     = 1'b1;
                be_next   = 4'b0001 << lsu.req_addr[1:0];
                wdata_rep = {4{lsu.req_wdata[7:0]}};
            end
            2'b01: begin
                legal     = !lsu.req_addr[0];
                be_next   = 4'b0011 << lsu.req_addr[1:0];
                wdata_rep = {2{lsu.req_wdata[15:0]}};
            end
            2'b10: begin
                legal     = (lsu.req_addr[1:0] == 2'b00);
                be_next   = 4'b1111;
                wdata_rep = lsu.req_wdata;
            end
            default: begin
                legal     = 1'b0;
                be_next   = 4'b0000;
                wdata_rep = lsu.req_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        lane     = lsu.mem_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            size_q         <= 2'b00;
            off_q          <= 2'b00;
            lsu.resp_valid <= 1'b0;
            lsu.resp_err   <= 1'b0;
            lsu.resp_rdata <= 32'd0;
            lsu.mem_req    <= 1'b0;
            lsu.mem_we     <= 1'b0;
            lsu.mem_addr   <= 32'd0;
            lsu.mem_be     <= 4'b0000;
            lsu.mem_wdata  <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            lsu.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        if (legal) begin
                            state         <= WAIT;
                            we_q          <= lsu.req_we;
                            uns_q         <= lsu.req_unsigned;
                            size_q        <= lsu.req_size;
                            off_q         <= lsu.req_addr[1:0];
                            lsu.mem_req   <= 1'b1;
                            lsu.mem_we    <= lsu.req_we;
                            lsu.mem_addr  <= {lsu.req_addr[31:2], 2'b00};
                            lsu.mem_be    <= be_next;
                            lsu.mem_wdata <= wdata_rep;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt      <= '0;
`endif
                        end else begin
                            state          <= RESP;
                            lsu.resp_valid <= 1'b1;
                            lsu.resp_err   <= 1'b1;
                            lsu.resp_rdata <= 32'd0;
                        end
                    end
                end
                WAIT: begin
                    // An ack coincident with the timeout completes normally.
                    if (lsu.mem_ack || timeout_hit) begin
                        state          <= RESP;
                        lsu.resp_valid <= 1'b1;
                        lsu.resp_err   <= !lsu.mem_ack;
                        lsu.resp_rdata <= (lsu.mem_ack && !we_q) ? load_ext : 32'd0;
                        lsu.mem_req    <= 1'b0;
                        lsu.mem_we     <= 1'b0;
                        lsu.mem_addr   <= 32'd0;
                        lsu.mem_be     <= 4'b0000;
                        lsu.mem_wdata  <= 32'd0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                RESP: begin
                    state          <= IDLE;
                    lsu.resp_err   <= 1'b0;
                    lsu.resp_rdata <= 32'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// transactions against an arithmetic reference model, reset and timeout sequences.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit        resp_seen;
        bit        err;
        bit [31:0] rdata;
        bit [3:0]  be;
        bit [31:0] maddr;
        bit [31:0] wdata;
        bit        mwe;
        int        waits;
        int        lat;
        bit        stable;
        bit        stall_ok;
        bit        ready_idle;
        bit        stall_idle;
        bit        after_ok;
    } txn_t;

    typedef struct {
        bit        we;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        delay;
        bit        exp_err;
        bit [3:0]  exp_be;
        bit [31:0] exp_maddr;
        bit [31:0] exp_wdata;
        bit [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: access of 2^size bytes, lane offset addr%4, arithmetic extension.
    function automatic void model(input bit we, input bit [1:0] size, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  input bit [31:0] rdata,
                                  output bit err, output bit [3:0] be,
                                  output bit [31:0] maddr, output bit [31:0] mwdata,
                                  output bit [31:0] rd);
        int nb;
        int off;
        int bem;
        longint unsigned mask;
        longint unsigned v;
        nb     = 1 << size;
        off    = int'(addr % 4);
        err    = (size == 2'b11) || ((addr % nb) != 0);
        bem    = ((1 << nb) - 1) << off;
        be     = err ? 4'b0000 : bem[3:0];
        maddr  = addr - off;
        mwdata = 32'd0;
        for (int i = 0; i < 4; i++)
            mwdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = ({32'd0, rdata} >> (8 * off)) & mask;
        if (!uns && v[8*nb-1])
            v = v | ~mask;
        rd = (we || err) ? 32'd0 : v[31:0];
    endfunction

    task automatic run_txn(input bit we, input bit [1:0] size, input bit uns,
                           input bit [31:0] addr, input bit [31:0] wdata,
                           input bit [31:0] rdata, input int delay, output txn_t r);
        r = '{default: 0};
        r.stable   = 1'b1;
        r.stall_ok = 1'b1;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.mem_ack      = 1'b1;
        bus.mem_rdata    = $urandom;
        #1;
        r.ready_idle = bus.req_ready;
        r.stall_idle = bus.stall;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.mem_ack      = 1'b0;
        for (int c = 1; c <= 40 && !r.resp_seen; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (!bus.stall) r.stall_ok = 1'b0;
                if (r.waits == 0) begin
                    r.be = bus.mem_be; r.maddr = bus.mem_addr;
                    r.wdata = bus.mem_wdata; r.mwe = bus.mem_we;
                end else if (r.be != bus.mem_be || r.maddr != bus.mem_addr ||
                             r.wdata != bus.mem_wdata || r.mwe != bus.mem_we) begin
                    r.stable = 1'b0;
                end
                r.waits++;
                bus.mem_ack   = ((r.waits - 1) == delay);
                bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
            end else begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
                if (bus.resp_valid) begin
                    r.resp_seen = 1'b1;
                    r.lat       = c;
                    r.err       = bus.resp_err;
                    r.rdata     = bus.resp_rdata;
                    if (bus.stall || bus.req_ready) r.stall_ok = 1'b0;
                end
            end
        end
        @(negedge clk);
        r.after_ok  = !bus.resp_valid && bus.req_ready && !bus.stall && !bus.mem_req;
        bus.mem_ack = 1'b0;
    endtask

    task automatic check_txn(input string tag, input txn_t r, input bit we, input int delay,
                             input bit exp_err, input bit [3:0] exp_be,
                             input bit [31:0] exp_maddr, input bit [31:0] exp_wdata,
                             input bit [31:0] exp_rdata);
        chk({tag, ".resp_seen"}, 32'(r.resp_seen), 32'd1);
        chk({tag, ".err"}, 32'(r.err), 32'(exp_err));
        chk({tag, ".rdata"}, r.rdata, exp_rdata);
        chk({tag, ".ready_idle"}, 32'(r.ready_idle), 32'd1);
        chk({tag, ".stall_idle"}, 32'(r.stall_idle), 32'd1);
        chk({tag, ".stall_wait_resp"}, 32'(r.stall_ok), 32'd1);
        chk({tag, ".single_resp"}, 32'(r.after_ok), 32'd1);
        if (exp_err) begin
            chk({tag, ".mem_req_cycles"}, 32'(r.waits), 32'd0);
            chk({tag, ".latency"}, 32'(r.lat), 32'd1);
        end else begin
            chk({tag, ".mem_be"}, 32'(r.be), 32'(exp_be));
            chk({tag, ".mem_addr"}, r.maddr, exp_maddr);
            chk({tag, ".mem_we"}, 32'(r.mwe), 32'(we));
            if (we) chk({tag, ".mem_wdata"}, r.wdata, exp_wdata);
            chk({tag, ".held_stable"}, 32'(r.stable), 32'd1);
            chk({tag, ".mem_req_cycles"}, 32'(r.waits), 32'(delay + 1));
            chk({tag, ".latency"}, 32'(r.lat), 32'(delay + 2));
        end
    endtask

    vec_t vecs[11];

    initial begin
        txn_t      r;
        bit        m_err;
        bit [3:0]  m_be;
        bit [31:0] m_maddr, m_wdata, m_rd;
        int        resp_cnt;

        n_tests = 0;
        n_fail  = 0;

        //         we  sz     uns addr          wdata          rdata          dly err be       maddr          wdata          rdata
        vecs[0]  = '{0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,         32'hFFFF_FF80};
        vecs[1]  = '{0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 1, 0, 4'b1100, 32'h0000_0100, 32'h0,         32'h0000_BEEF};
        vecs[2]  = '{1, 2'b00, 0, 32'h0000_0201, 32'h0000_00AB, 32'h1357_9BDF, 0, 0, 4'b0010, 32'h0000_0200, 32'hABAB_ABAB, 32'h0};
        vecs[3]  = '{0, 2'b10, 0, 32'h0000_0006, 32'h0,         32'h1111_1111, 0, 1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[4]  = '{0, 2'b01, 0, 32'h0000_0101, 32'h0,         32'h2222_2222, 0, 1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[5]  = '{1, 2'b11, 0, 32'h0000_0100, 32'h5555_5555, 32'h3333_3333, 0, 1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[6]  = '{0, 2'b10, 0, 32'h0000_010C, 32'h0,         32'hDEAD_BEEF, 2, 0, 4'b1111, 32'h0000_010C, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{1, 2'b01, 0, 32'h0000_0302, 32'h1234_5678, 32'h0,         1, 0, 4'b1100, 32'h0000_0300, 32'h5678_5678, 32'h0};
        vecs[8]  = '{0, 2'b01, 0, 32'h0000_0000, 32'h0,         32'h0000_8001, 0, 0, 4'b0011, 32'h0000_0000, 32'h0,         32'hFFFF_8001};
        vecs[9]  = '{0, 2'b00, 1, 32'h0000_0001, 32'h0,         32'h0000_F000, 0, 0, 4'b0010, 32'h0000_0000, 32'h0,         32'h0000_00F0};
        vecs[10] = '{1, 2'b10, 0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,         3, 0, 4'b1111, 32'h0000_0400, 32'hCAFE_F00D, 32'h0};

        rst_n            = 1'b0;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0000_0100;
        bus.req_wdata    = 32'hFFFF_FFFF;
        bus.mem_ack      = 1'b1;
        bus.mem_rdata    = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst.mem_be", 32'(bus.mem_be), 32'd0);
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        chk("idle.stall_no_req", 32'(bus.stall), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].delay, r);
            check_txn($sformatf("vec%0d", i), r, vecs[i].we, vecs[i].delay, vecs[i].exp_err,
                      vecs[i].exp_be, vecs[i].exp_maddr, vecs[i].exp_wdata, vecs[i].exp_rdata);
        end

        for (int i = 0; i < 150; i++) begin
            bit        we, uns;
            bit [1:0]  size;
            bit [31:0] addr, wdata, rdata;
            int        dly;
            we    = 1'($urandom);
            uns   = 1'($urandom);
            size  = 2'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            dly   = $urandom_range(0, TMO - 1);
            model(we, size, uns, addr, wdata, rdata, m_err, m_be, m_maddr, m_wdata, m_rd);
            run_txn(we, size, uns, addr, wdata, rdata, dly, r);
            check_txn($sformatf("rnd%0d", i), r, we, dly, m_err, m_be, m_maddr, m_wdata, m_rd);
        end

        // Reset pulled asynchronously while a load is outstanding.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_0500;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("arst.mem_req_before", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("arst.stall", 32'(bus.stall), 32'd0);
        chk("arst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst.mem_be", 32'(bus.mem_be), 32'd0);
        chk("arst.mem_addr", bus.mem_addr, 32'd0);
        bus.mem_ack = 1'b1;
        resp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) resp_cnt++;
        end
        bus.mem_ack = 1'b0;
        rst_n       = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid) resp_cnt++;
        end
        chk("arst.no_resp", 32'(resp_cnt), 32'd0);
        run_txn(vecs[0].we, vecs[0].size, vecs[0].uns, vecs[0].addr, vecs[0].wdata,
                vecs[0].rdata, vecs[0].delay, r);
        check_txn("arst.after", r, vecs[0].we, vecs[0].delay, vecs[0].exp_err,
                  vecs[0].exp_be, vecs[0].exp_maddr, vecs[0].exp_wdata, vecs[0].exp_rdata);

`ifdef LSU_TIMEOUT_EN
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 32'h7777_7777, 1000, r);
        chk("tmo.resp_seen", 32'(r.resp_seen), 32'd1);
        chk("tmo.err", 32'(r.err), 32'd1);
        chk("tmo.rdata", r.rdata, 32'd0);
        chk("tmo.wait_cycles", 32'(r.waits), 32'(TMO));
        chk("tmo.latency", 32'(r.lat), 32'(TMO + 1));
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 32'h7777_7777, TMO - 1, r);
        chk("tmo_ack.err", 32'(r.err), 32'd0);
        chk("tmo_ack.rdata", r.rdata, 32'h7777_7777);
        chk("tmo_ack.wait_cycles", 32'(r.waits), 32'(TMO));
`else
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0603, 32'h0, 32'hA500_0000, 20, r);
        chk("long_wait.resp_seen", 32'(r.resp_seen), 32'd1);
        chk("long_wait.err", 32'(r.err), 32'd0);
        chk("long_wait.rdata", r.rdata, 32'h0000_00A5);
        chk("long_wait.wait_cycles", 32'(r.waits), 32'd21);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
